// File: rtl/tick_timer_scheduler_if.sv
// Configuration, readback and status bundle between a controller and the tick timer block.
interface tick_timer_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              wr_en;
  logic [CH_W-1:0]   wr_chan;
  logic [CNT_W-1:0]  wr_value;
  logic              wr_src;
  logic              wr_periodic;
  logic              stop_en;
  logic [CH_W-1:0]   stop_chan;
  logic [CH_W-1:0]   rd_chan;
  logic [CNT_W-1:0]  rd_count;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] overrun;
  logic              busy;

  // Controller side: issues writes/stops/readback selects, observes status.
  modport master (
    output wr_en, wr_chan, wr_value, wr_src, wr_periodic,
    output stop_en, stop_chan, rd_chan,
    input  rd_count, active, expired, overrun, busy
  );

  // Timer side.
  modport slave (
    input  wr_en, wr_chan, wr_value, wr_src, wr_periodic,
    input  stop_en, stop_chan, rd_chan,
    output rd_count, active, expired, overrun, busy
  );
endinterface

// File: rtl/tick_timer_scheduler.sv
// Multi-channel countdown timers sharing one decrementer, serviced round-robin.
module tick_timer_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_1kHz_i,
  input  logic                  tick_1Hz_i,
  tick_timer_scheduler_if.slave tmr_if
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  reload_q [NUM_CH];
  logic [CNT_W-1:0]  reload_d [NUM_CH];
  logic [NUM_CH-1:0] src_q, src_d;
  logic [NUM_CH-1:0] periodic_q, periodic_d;
  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] expired_q, expired_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;

  // Round-robin search: first serviceable channel at or after the pointer.
  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] cidx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cidx      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cidx = CH_W'(idx);
      if (!grant_vld && pending_q[cidx] && active_q[cidx]) begin
        grant_vld = 1'b1;
        grant_idx = cidx;
      end
    end
  end

  // Per-channel next state: write beats stop, stop beats service/tick capture.
  always_comb begin
    logic [CH_W-1:0] ch;
    logic tick_hit;
    logic do_wr;
    logic do_stop;
    logic granted;

    count_d    = count_q;
    reload_d   = reload_q;
    src_d      = src_q;
    periodic_d = periodic_q;
    active_d   = active_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    expired_d  = '0;
    ch         = '0;
    tick_hit   = 1'b0;
    do_wr      = 1'b0;
    do_stop    = 1'b0;
    granted    = 1'b0;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch       = CH_W'(i);
      tick_hit = active_q[ch] & (src_q[ch] ? tick_1Hz_i : tick_1kHz_i);
      do_wr    = tmr_if.wr_en && (tmr_if.wr_chan == ch);
      do_stop  = tmr_if.stop_en && (tmr_if.stop_chan == ch) && !do_wr;
      granted  = grant_vld && (grant_idx == ch);

      if (do_wr) begin
        overrun_d[ch] = 1'b0;
        pending_d[ch] = 1'b0;
        if (tmr_if.wr_value != '0) begin
          count_d[ch]    = tmr_if.wr_value;
          reload_d[ch]   = tmr_if.wr_value;
          src_d[ch]      = tmr_if.wr_src;
          periodic_d[ch] = tmr_if.wr_periodic;
          active_d[ch]   = 1'b1;
        end else begin
          active_d[ch]   = 1'b0;
        end
      end else if (do_stop) begin
        active_d[ch]  = 1'b0;
        pending_d[ch] = 1'b0;
      end else begin
        // A second tick before service is lost; the granted channel absorbs it.
        if (tick_hit && pending_q[ch] && !granted) overrun_d[ch] = 1'b1;
        if (granted) begin
          if (count_q[ch] > CNT_W'(1)) begin
            count_d[ch] = count_q[ch] - CNT_W'(1);
          end else begin
            expired_d[ch] = 1'b1;
            if (periodic_q[ch]) begin
              count_d[ch] = reload_q[ch];
            end else begin
              count_d[ch]  = '0;
              active_d[ch] = 1'b0;
            end
          end
          pending_d[ch] = tick_hit & active_d[ch];
        end else begin
          pending_d[ch] = pending_q[ch] | tick_hit;
        end
      end
    end
  end

  // Pointer advance and readback capture of the pre-edge count.
  always_comb begin
    ptr_d      = ptr_q;
    rd_count_d = count_q[tmr_if.rd_chan];
    if (grant_vld) begin
      ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count_q[CH_W'(i)]  <= '0;
        reload_q[CH_W'(i)] <= '0;
      end
      src_q      <= '0;
      periodic_q <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      expired_q  <= '0;
      rd_count_q <= '0;
      ptr_q      <= '0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      src_q      <= src_d;
      periodic_q <= periodic_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      expired_q  <= expired_d;
      rd_count_q <= rd_count_d;
      ptr_q      <= ptr_d;
    end
  end

  assign tmr_if.rd_count = rd_count_q;
  assign tmr_if.active   = active_q;
  assign tmr_if.expired  = expired_q;
  assign tmr_if.overrun  = overrun_q;
  assign tmr_if.busy     = |pending_q;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Self-checking bench for tick_timer_scheduler: directed scenarios plus randomized run vs reference model.
module tb_tick_timer_scheduler;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CH_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic t1k = 1'b0;
  logic t1h = 1'b0;

  int checks = 0;
  int errors = 0;

  tick_timer_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  tick_timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_1kHz_i (t1k),
    .tick_1Hz_i  (t1h),
    .tmr_if      (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: channel state updated once per clock edge from the behavioural rules.
  int m_count [NUM_CH];
  int m_reload[NUM_CH];
  bit m_src   [NUM_CH];
  bit m_per   [NUM_CH];
  bit m_act   [NUM_CH];
  bit m_pend  [NUM_CH];
  bit m_ovr   [NUM_CH];
  bit m_exp   [NUM_CH];
  int m_ptr = 0;
  int m_rd  = 0;

  always @(posedge clk) begin
    int g;
    int new_rd;
    bit hit[NUM_CH];
    bit wr, st;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_count[c] = 0; m_reload[c] = 0; m_src[c] = 0; m_per[c] = 0;
        m_act[c] = 0; m_pend[c] = 0; m_ovr[c] = 0; m_exp[c] = 0;
      end
      m_ptr = 0;
      m_rd  = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_ptr + k) % NUM_CH;
        if (g < 0 && m_pend[c] && m_act[c]) g = c;
      end
      new_rd = m_count[int'(bus.rd_chan)];
      for (int c = 0; c < NUM_CH; c++) begin
        hit[c]   = m_act[c] && (m_src[c] ? t1h : t1k);
        m_exp[c] = 0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        wr = bus.wr_en && (int'(bus.wr_chan) == c);
        st = bus.stop_en && (int'(bus.stop_chan) == c) && !wr;
        if (wr) begin
          m_ovr[c]  = 0;
          m_pend[c] = 0;
          if (bus.wr_value != 0) begin
            m_count[c] = int'(bus.wr_value); m_reload[c] = int'(bus.wr_value);
            m_src[c] = bus.wr_src; m_per[c] = bus.wr_periodic; m_act[c] = 1;
          end else begin
            m_act[c] = 0;
          end
        end else if (st) begin
          m_act[c]  = 0;
          m_pend[c] = 0;
        end else begin
          if (hit[c] && m_pend[c] && c != g) m_ovr[c] = 1;
          if (c == g) begin
            if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
            else begin
              m_exp[c] = 1;
              if (m_per[c]) m_count[c] = m_reload[c];
              else begin m_count[c] = 0; m_act[c] = 0; end
            end
            m_pend[c] = hit[c] && m_act[c];
          end else begin
            m_pend[c] = m_pend[c] || hit[c];
          end
        end
      end
      if (g >= 0) m_ptr = (g + 1) % NUM_CH;
      m_rd = new_rd;
    end
  end

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_chan = '0; bus.wr_value = '0; bus.wr_src = 0; bus.wr_periodic = 0;
    bus.stop_en = 0; bus.stop_chan = '0; bus.rd_chan = '0;
    t1k = 0; t1h = 0;
  endtask

  task automatic do_reset();
    rst = 1; clk_step(); clk_step(); rst = 0;
  endtask

  task automatic write_ch(input int ch, input int val, input bit src, input bit per);
    bus.wr_en = 1; bus.wr_chan = CH_W'(ch); bus.wr_value = CNT_W'(val);
    bus.wr_src = src; bus.wr_periodic = per;
    clk_step();
    bus.wr_en = 0;
  endtask

  task automatic pulse_1k();
    t1k = 1; clk_step(); t1k = 0;
  endtask

  task automatic pulse_1h();
    t1h = 1; clk_step(); t1h = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rd_count !== '0) begin errors++; $display("FAIL reset_rd_count got %0d want 0", bus.rd_count); end
    checks++; if (bus.active !== '0) begin errors++; $display("FAIL reset_active got %b want 0000", bus.active); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    bus.rd_chan = '0;
    write_ch(0, 5, 0, 0);
    pulse_1k(); repeat (3) clk_step();
    pulse_1k(); repeat (3) clk_step();
    checks++; if (bus.rd_count !== 16'd3) begin errors++; $display("FAIL pre_reset_count got %0d want 3", bus.rd_count); end
    rst = 1; clk_step(); rst = 0;
    checks++; if (bus.active !== '0) begin errors++; $display("FAIL midrun_active got %b want 0000", bus.active); end
    checks++; if (bus.rd_count !== '0) begin errors++; $display("FAIL midrun_rd_count got %0d want 0", bus.rd_count); end
    checks++; if (bus.expired !== '0) begin errors++; $display("FAIL midrun_expired got %b want 0000", bus.expired); end
    checks++; if (bus.overrun !== '0) begin errors++; $display("FAIL midrun_overrun got %b want 0000", bus.overrun); end
    pulse_1k(); repeat (3) clk_step();
    checks++; if (bus.active !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL tick_after_reset active %b busy %b want 0000 0", bus.active, bus.busy); end
    checks++; if (bus.rd_count !== '0) begin errors++; $display("FAIL tick_after_reset_count got %0d want 0", bus.rd_count); end
  endtask

  task automatic test_one_shot();
    int pulses, first;
    do_reset();
    bus.rd_chan = CH_W'(0);
    write_ch(0, 3, 0, 0);
    for (int t = 0; t < 4; t++) begin
      pulse_1k();
      pulses = 0; first = -1;
      for (int i = 0; i < 31; i++) begin
        if (bus.expired[0]) begin pulses++; if (first < 0) first = i; end
        clk_step();
      end
      checks++;
      if (bus.rd_count !== CNT_W'((t < 3) ? 2 - t : 0)) begin
        errors++; $display("FAIL oneshot_count tick %0d got %0d want %0d", t, bus.rd_count, (t < 3) ? 2 - t : 0);
      end
      checks++;
      if (pulses != ((t == 2) ? 1 : 0)) begin
        errors++; $display("FAIL oneshot_pulses tick %0d got %0d want %0d", t, pulses, (t == 2) ? 1 : 0);
      end
      if (t == 2) begin
        checks++;
        if (first != 1) begin errors++; $display("FAIL oneshot_latency got %0d want 1", first); end
        checks++;
        if (bus.active[0] !== 1'b0) begin errors++; $display("FAIL oneshot_active got %b want 0", bus.active[0]); end
      end
    end
  endtask

  task automatic test_periodic_1hz();
    int pulses, others;
    do_reset();
    bus.rd_chan = CH_W'(2);
    write_ch(2, 2, 1, 1);
    for (int t = 0; t < 4; t++) begin
      pulse_1h();
      pulses = 0; others = 0;
      for (int i = 0; i < 31; i++) begin
        t1k = (i == 10);
        if (bus.expired[2]) pulses++;
        if ((bus.expired & 4'b1011) != 0) others++;
        clk_step();
      end
      t1k = 0;
      checks++;
      if (pulses != ((t % 2 == 1) ? 1 : 0)) begin
        errors++; $display("FAIL periodic_pulses tick %0d got %0d want %0d", t, pulses, (t % 2 == 1) ? 1 : 0);
      end
      checks++;
      if (bus.rd_count !== CNT_W'((t % 2 == 0) ? 1 : 2)) begin
        errors++; $display("FAIL periodic_count tick %0d got %0d want %0d", t, bus.rd_count, (t % 2 == 0) ? 1 : 2);
      end
      checks++;
      if (bus.active[2] !== 1'b1 || others != 0) begin
        errors++; $display("FAIL periodic_active tick %0d active %b stray %0d want 1 0", t, bus.active[2], others);
      end
    end
  endtask

  task automatic test_round_robin();
    int busy_cnt;
    logic [NUM_CH-1:0] ev;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) write_ch(c, 1, 0, 1);
    for (int rep = 0; rep < 2; rep++) begin
      pulse_1k();
      busy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        ev = '0;
        if (i >= 1 && i <= 4) ev[i-1] = 1'b1;
        checks++;
        if (bus.expired !== ev) begin
          errors++; $display("FAIL rr_expired rep %0d cycle %0d got %b want %b", rep, i, bus.expired, ev);
        end
        if (bus.busy === 1'b1) busy_cnt++;
        clk_step();
      end
      checks++;
      if (busy_cnt != 4) begin errors++; $display("FAIL rr_busy_cycles rep %0d got %0d want 4", rep, busy_cnt); end
    end
  endtask

  task automatic test_collisions();
    int pulses;
    do_reset();
    bus.rd_chan = CH_W'(1);
    write_ch(1, 1, 0, 0);
    pulse_1k();
    bus.wr_en = 1; bus.wr_chan = CH_W'(1); bus.wr_value = CNT_W'(7); bus.wr_src = 0; bus.wr_periodic = 0;
    clk_step();
    bus.wr_en = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.expired !== '0) pulses++;
      clk_step();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL wr_vs_grant_expiry got %0d pulses want 0", pulses); end
    checks++; if (bus.rd_count !== 16'd7) begin errors++; $display("FAIL wr_vs_grant_count got %0d want 7", bus.rd_count); end
    bus.wr_en = 1; bus.wr_chan = CH_W'(1); bus.wr_value = CNT_W'(9);
    bus.stop_en = 1; bus.stop_chan = CH_W'(1);
    clk_step();
    bus.wr_en = 0; bus.stop_en = 0;
    checks++; if (bus.active[1] !== 1'b1) begin errors++; $display("FAIL wr_beats_stop got %b want 1", bus.active[1]); end
    bus.stop_en = 1; bus.stop_chan = CH_W'(1);
    clk_step();
    bus.stop_en = 0;
    checks++; if (bus.active[1] !== 1'b0) begin errors++; $display("FAIL stop_active got %b want 0", bus.active[1]); end
    clk_step(); clk_step();
    checks++; if (bus.rd_count !== 16'd9) begin errors++; $display("FAIL stop_count_held got %0d want 9", bus.rd_count); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int c = 0; c < NUM_CH; c++) write_ch(c, 5, 0, 0);
    t1k = 1; clk_step(); clk_step(); t1k = 0;
    clk_step(); clk_step();
    checks++; if (bus.overrun[3] !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", bus.overrun[3]); end
    checks++; if (bus.overrun[0] !== 1'b0) begin errors++; $display("FAIL overrun_granted_ch got %b want 0", bus.overrun[0]); end
    repeat (40) clk_step();
    checks++; if (bus.overrun[3] !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", bus.overrun[3]); end
    write_ch(3, 5, 0, 0);
    checks++; if (bus.overrun[3] !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", bus.overrun[3]); end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] ma, me, mo;
    logic mb;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 499) == 0);
      bus.wr_en       = ($urandom_range(0, 11) == 0);
      bus.wr_chan     = CH_W'($urandom_range(0, NUM_CH - 1));
      bus.wr_value    = CNT_W'($urandom_range(0, 5));
      bus.wr_src      = 1'($urandom_range(0, 1));
      bus.wr_periodic = 1'($urandom_range(0, 1));
      bus.stop_en     = ($urandom_range(0, 29) == 0);
      bus.stop_chan   = CH_W'($urandom_range(0, NUM_CH - 1));
      bus.rd_chan     = CH_W'($urandom_range(0, NUM_CH - 1));
      t1k             = ($urandom_range(0, 5) == 0);
      t1h             = ($urandom_range(0, 9) == 0);
      clk_step();
      ma = '0; me = '0; mo = '0; mb = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ma[c] = m_act[c]; me[c] = m_exp[c]; mo[c] = m_ovr[c]; mb = mb | m_pend[c];
      end
      checks++; if (bus.rd_count !== CNT_W'(m_rd)) begin errors++; $display("FAIL rand_rd_count cycle %0d got %0d want %0d", n, bus.rd_count, m_rd); end
      checks++; if (bus.active !== ma) begin errors++; $display("FAIL rand_active cycle %0d got %b want %b", n, bus.active, ma); end
      checks++; if (bus.expired !== me) begin errors++; $display("FAIL rand_expired cycle %0d got %b want %b", n, bus.expired, me); end
      checks++; if (bus.overrun !== mo) begin errors++; $display("FAIL rand_overrun cycle %0d got %b want %b", n, bus.overrun, mo); end
      checks++; if (bus.busy !== mb) begin errors++; $display("FAIL rand_busy cycle %0d got %b want %b", n, bus.busy, mb); end
    end
    idle_inputs();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_periodic_1hz();
    test_round_robin();
    test_collisions();
    test_overrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
